cache_line_adapter: RTL and testbench

Memory-side stage directly downstream of the cache controller. It carries out the controller's `readmem` (line fill) and `write` (writeback) phases. Each 256-bit cache-line request is converted into a 4-beat, 64-bit burst transaction on the burst-memory port. Read beats are gathered back into a full line, and completion is signalled to the cache with a one-cycle `dfp_resp` pulse.

---
 rtl/cache_line_adapter.sv | 138 +++++++++++++
 tb/tb_cache_line_adapter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_adapter.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_adapter
// Purpose  : Converts 256-bit cache line fills/writebacks into 4-beat 64-bit
//            bursts and gathers read beats back into a full line.
// Revision : 1.0
// ============================================================================
module cache_line_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int LINE_BYTES = LINE_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CMD   = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WR_BEATS = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] line_q;

    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic                  w_last;
    logic                  w_beat_hit;
    logic [LINE_WIDTH-1:0] w_fill_line;

    // Masking (rather than slicing) keeps every address bit in use.
    assign w_req_addr = dfp_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
    assign cnt_d      = cnt_q + 1'b1;
    assign w_last     = (cnt_q == CNT_W'(BEATS - 1));
    assign w_beat_hit = bmem_rvalid && (bmem_raddr == addr_q);

    always_comb begin
        w_fill_line = line_q;
        w_fill_line[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            dfp_resp <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    // Writeback has priority so a dirty victim leaves before the fill.
                    if (dfp_write) begin
                        addr_q     <= w_req_addr;
                        line_q     <= dfp_wdata;
                        bmem_addr  <= w_req_addr;
                        bmem_write <= 1'b1;
                        bmem_wdata <= dfp_wdata[BEAT_WIDTH-1:0];
                        state_q    <= S_WR_BEATS;
                    end else if (dfp_read) begin
                        addr_q    <= w_req_addr;
                        bmem_addr <= w_req_addr;
                        bmem_read <= 1'b1;
                        state_q   <= S_RD_CMD;
                    end
                end
                S_RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_beat_hit) begin
                        line_q <= w_fill_line;
                        cnt_q  <= cnt_d;
                        if (w_last) begin
                            dfp_rdata <= w_fill_line;
                            dfp_resp  <= 1'b1;
                            state_q   <= S_RESP;
                        end
                    end
                end
                S_WR_BEATS: begin
                    if (bmem_ready) begin
                        if (w_last) begin
                            bmem_write <= 1'b0;
                            dfp_resp   <= 1'b1;
                            state_q    <= S_RESP;
                        end else begin
                            cnt_q      <= cnt_d;
                            bmem_wdata <= line_q[int'(cnt_d)*BEAT_WIDTH +: BEAT_WIDTH];
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_adapter
// Purpose  : Directed stimulus with queue-based scoreboard for the adapter.
// Revision : 1.0
// ============================================================================
module tb_cache_line_adapter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  dfp_addr = '0;
    logic         dfp_read = 1'b0;
    logic         dfp_write = 1'b0;
    logic [255:0] dfp_wdata = '0;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b0;
    logic [31:0]  bmem_raddr = '0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [255:0] exp_resp[$];
    logic [31:0]  exp_cmd[$];
    logic [95:0]  exp_wb[$];
    logic [255:0] mdl_rdata = '0;

    cache_line_adapter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .BEAT_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake or response.
    logic        resp_due = 1'b0;
    logic        rd_active = 1'b0;
    logic [31:0] rd_addr = '0;
    int          rd_hits = 0;
    int          wr_hits = 0;
    logic        p_read = 1'b0, p_write = 1'b0, p_ready = 1'b0;
    logic [31:0] p_addr = '0;
    logic [63:0] p_wdata = '0;

    always @(negedge clk) begin
        logic [95:0] wb;
        if (!rst_n) begin
            resp_due = 1'b0; rd_active = 1'b0; rd_hits = 0; wr_hits = 0;
            p_read = 1'b0; p_write = 1'b0; p_ready = 1'b0;
        end else begin
            if (dfp_resp || resp_due) begin
                chk("resp_timing", {255'd0, dfp_resp}, {255'd0, resp_due});
                if (dfp_resp) begin
                    if (exp_resp.size() == 0) chk("resp_unexpected", 256'd1, 256'd0);
                    else chk("dfp_rdata", dfp_rdata, exp_resp.pop_front());
                end
            end
            resp_due = 1'b0;
            if (bmem_read && bmem_ready) begin
                if (exp_cmd.size() == 0) chk("cmd_unexpected", 256'd1, 256'd0);
                else begin
                    rd_addr = exp_cmd.pop_front();
                    chk("cmd_addr", {224'd0, bmem_addr}, {224'd0, rd_addr});
                    rd_active = 1'b1;
                    rd_hits = 0;
                end
            end else if (rd_active && bmem_rvalid && bmem_raddr == rd_addr) begin
                rd_hits++;
                if (rd_hits == 4) begin rd_active = 1'b0; resp_due = 1'b1; end
            end
            if (bmem_write && bmem_ready) begin
                if (exp_wb.size() == 0) chk("wbeat_unexpected", 256'd1, 256'd0);
                else begin
                    wb = exp_wb.pop_front();
                    chk("wbeat_addr", {224'd0, bmem_addr}, {224'd0, wb[95:64]});
                    chk("wbeat_data", {192'd0, bmem_wdata}, {192'd0, wb[63:0]});
                    wr_hits++;
                    if (wr_hits == 4) begin wr_hits = 0; resp_due = 1'b1; end
                end
            end
            if (p_read && !p_ready)
                chk("rd_cmd_hold", {223'd0, bmem_read, bmem_addr}, {223'd0, 1'b1, p_addr});
            if (p_write && !p_ready)
                chk("wbeat_hold", {159'd0, bmem_write, bmem_addr, bmem_wdata}, {159'd0, 1'b1, p_addr, p_wdata});
            p_read = bmem_read; p_write = bmem_write; p_ready = bmem_ready;
            p_addr = bmem_addr; p_wdata = bmem_wdata;
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_rdata"}, dfp_rdata, 256'd0);
        chk({tag, "_ctrl"}, {253'd0, dfp_resp, bmem_read, bmem_write}, 256'd0);
        chk({tag, "_baddr"}, {224'd0, bmem_addr}, 256'd0);
        chk({tag, "_bwdata"}, {192'd0, bmem_wdata}, 256'd0);
    endtask

    // abort_after > 0: pulse reset once that many beats have been accepted.
    task automatic run_fill(input logic [31:0] a, input int rdy_delay, input logic [255:0] line,
                            input bit stray, input int abort_after);
        logic [31:0] al;
        int  k, b, phase;
        bit  done, stray_done;
        al = {a[31:5], 5'b0};
        k = 0; b = 0; phase = 0; done = 0; stray_done = 0;
        exp_cmd.push_back(al);
        if (abort_after == 0) begin exp_resp.push_back(line); mdl_rdata = line; end
        dfp_addr = a;
        dfp_read = 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk); #1;
            bmem_rvalid = 1'b0;
            bmem_ready  = 1'b0;
            case (phase)
                0: if (bmem_read) begin
                    if (k >= rdy_delay) begin bmem_ready = 1'b1; phase = 1; end
                    else k++;
                end
                1: begin
                    bmem_rvalid = 1'b1;
                    if (stray && b == 2 && !stray_done) begin
                        bmem_raddr = al ^ 32'h0000_0100;
                        bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                        stray_done = 1;
                    end else begin
                        bmem_raddr = al;
                        bmem_rdata = line[b*64 +: 64];
                        b++;
                        if (b == 4) phase = 2;
                        if (abort_after != 0 && b == abort_after) phase = 3;
                    end
                end
                2: if (dfp_resp) begin dfp_read = 1'b0; done = 1; end
                default: begin
                    rst_n = 1'b0;
                    #1;
                    check_zero_outputs("async_rst");
                    dfp_read = 1'b0;
                    mdl_rdata = '0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    done = 1;
                end
            endcase
        end
        if (!done) begin dfp_read = 1'b0; chk("fill_timeout", 256'd1, 256'd0); end
    endtask

    task automatic run_write(input logic [31:0] a, input logic [255:0] line, input bit toggle);
        logic [31:0] al;
        int  t;
        bit  done;
        al = {a[31:5], 5'b0};
        t = 0; done = 0;
        for (int b = 0; b < 4; b++) exp_wb.push_back({al, line[b*64 +: 64]});
        exp_resp.push_back(mdl_rdata);
        dfp_addr  = a;
        dfp_wdata = line;
        dfp_write = 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk); #1;
            bmem_ready  = 1'b0;
            bmem_rvalid = 1'b0;
            if (dfp_resp) begin dfp_write = 1'b0; done = 1; end
            else if (bmem_write) begin
                bmem_ready = toggle ? (t % 2 == 0) : 1'b1;
                t++;
            end
        end
        if (!done) begin dfp_write = 1'b0; chk("write_timeout", 256'd1, 256'd0); end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
    localparam logic [255:0] LINE_W = {64'hD3D3_D3D3_0000_0003, 64'hC2C2_C2C2_0000_0002,
                                       64'hB1B1_B1B1_0000_0001, 64'hA0A0_A0A0_0000_0000};
    localparam logic [255:0] LINE_C = {64'h8888_0000_8888_0003, 64'h7777_0000_7777_0002,
                                       64'h6666_0000_6666_0001, 64'h5555_0000_5555_0000};

    initial begin
        #2;
        check_zero_outputs("reset");
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);

        run_fill(32'h1234_5678, 0, LINE_A, 1'b0, 0);
        idle_cycles(2);
        run_fill(32'h0000_1040, 3, LINE_B, 1'b0, 0);
        idle_cycles(2);
        run_write(32'h8000_00FF, LINE_W, 1'b1);
        idle_cycles(2);

        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_2000;
        bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        idle_cycles(3);
        bmem_rvalid = 1'b0;
        run_fill(32'h0000_2010, 1, LINE_C, 1'b1, 0);
        idle_cycles(2);

        dfp_read = 1'b1;
        run_write(32'h0000_4000, LINE_B, 1'b0);
        run_fill(32'h0000_5000, 0, LINE_W, 1'b0, 0);
        idle_cycles(2);

        run_fill(32'h0000_6000, 0, LINE_C, 1'b0, 3);
        idle_cycles(4);
        run_fill(32'h0000_7020, 2, LINE_A, 1'b0, 0);
        idle_cycles(4);

        chk("resp_q_empty", 256'(exp_resp.size()), 256'd0);
        chk("cmd_q_empty",  256'(exp_cmd.size()),  256'd0);
        chk("wb_q_empty",   256'(exp_wb.size()),   256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
